vga_timing: RTL and testbench
=============================

// Module: vga_timing
// PURPOSE
//  Generates VGA raster timing: hsync, vsync, pixel x/y coordinates and data-enable.
//  First stage of the video pipeline; its outputs drive vga_buffer register stages
//  port-for-port (out_hsync/out_vsync/out_hdata/out_vdata/out_de -> in_*).
//  Timing is fully parameterised. A clock-enable input allows a pixel clock slower than clk.
// PARAMETERS
//  WIDTH    11   coordinate width; must hold max(H_TOTAL, V_TOTAL) - 1
//  H_ACTIVE 640  visible pixels per line
//  H_FP     16   horizontal front porch, pixels
//  H_SYNC   96   horizontal sync width, pixels
//  H_BP     48   horizontal back porch, pixels
//  V_ACTIVE 480  visible lines per frame
//  V_FP     10   vertical front porch, lines
//  V_SYNC   2    vertical sync width, lines
//  V_BP     33   vertical back porch, lines
//  H_POL    0    hsync active level (0 = active-low)
//  V_POL    0    vsync active level (0 = active-low)
// PORTS
//  clk        in   1      system clock; all logic on rising edge
//  rst        in   1      synchronous reset, active-high
//  ce         in   1      pixel enable; 0 freezes counters and all outputs
//  out_hsync  out  1      horizontal sync, polarity per H_POL
//  out_vsync  out  1      vertical sync, polarity per V_POL
//  out_hdata  out  WIDTH  horizontal count (pixel x), 0..H_TOTAL-1
//  out_vdata  out  WIDTH  vertical count (line y), 0..V_TOTAL-1
//  out_de     out  1      1 while in the visible area
//  out_frame  out  1      one-ce-cycle pulse when outputs show (0,0)
// BEHAVIOUR
//  - One clock, synchronous active-high reset. All outputs are registers.
//  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
//  - Internal counters: hc, vc (WIDTH bits).
//  - Reset: hc=vc=0, out_hdata=out_vdata=0, out_de=0, out_frame=0,
//    out_hsync=~H_POL, out_vsync=~V_POL (inactive levels).
//  - Each clk edge with rst=0 and ce=1:
//    - Outputs are loaded from the current (hc, vc). Latency is 1 clk, counter to output.
//    - out_hdata=hc; out_vdata=vc.
//    - out_de = (hc<H_ACTIVE) && (vc<V_ACTIVE).
//    - out_hsync = H_POL when H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC; otherwise ~H_POL.
//    - out_vsync = V_POL when V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC; otherwise ~V_POL.
//      vsync is line-aligned: it changes together with hdata=0.
//    - out_frame = (hc==0 && vc==0).
//    - Counter update: hc increments. When hc==H_TOTAL-1, hc wraps to 0 and vc increments.
//      When vc==V_TOTAL-1 on that same cycle, vc wraps to 0.
//  - ce=0 with rst=0: counters and every output hold, including out_frame.
//    A frame pulse therefore lasts exactly one ce=1 cycle.
//  - rst takes priority over ce. Reset mid-frame aborts the frame.
//    The first ce=1 cycle after rst deasserts shows (0,0) with de=1 and frame=1.
//  - No out-of-range count is ever produced; all counter arithmetic is unsigned, WIDTH bits.
// TESTING  (small params: H 4/1/2/1 -> H_TOTAL=8; V 3/1/1/1 -> V_TOTAL=6; ce=1 unless stated)
//  1. Assert rst for 2 clk -> hsync=1, vsync=1, de=0, hdata=0, vdata=0, frame=0.
//     Release rst -> next outputs hdata=0, vdata=0, de=1, frame=1.
//  2. Line scan -> hdata steps 0..7 then 0; de=1 for hdata 0..3; hsync=0 for hdata 5,6 only;
//     vdata 0->1 on the same cycle that hdata returns to 0.
//  3. Full frame -> frame pulses exactly every 48 clk; de=0 for all of vdata 3..5;
//     vsync=0 for the 8 cycles of vdata=4.
//  4. Drop ce for 3 clk while hdata=2 -> all outputs frozen for 3 clk;
//     after ce returns, hdata=3 with no pixel skipped.
//  5. Assert rst for 1 clk at hdata=6, vdata=4 -> reset values on the next clk;
//     then restart at (0,0) with frame=1 and vsync=1.
//  6. Set H_POL=1, V_POL=1 -> hsync=1 only at hdata 5,6; vsync=1 only during vdata=4;
//     reset levels hsync=0 and vsync=0.

Source files
------------

// File: rtl/vga_timing.sv
// ---------------------------------------------------------------------------
// vga_timing
//   Raster timing generator: free-running horizontal/vertical counters that
//   produce hsync, vsync, pixel coordinates, data-enable and a frame pulse.
//   All outputs are registered one clk after the counter value they describe.
//   A pixel enable (ce) allows a pixel rate slower than clk; ce=0 freezes
//   the counters and every output, including the frame pulse.
//
// Ports
//   clk        in   1      system clock, rising edge
//   rst        in   1      synchronous reset, active-high (priority over ce)
//   ce         in   1      pixel enable
//   out_hsync  out  1      horizontal sync, active level H_POL
//   out_vsync  out  1      vertical sync, active level V_POL (line-aligned)
//   out_hdata  out  WIDTH  pixel x, 0..H_TOTAL-1
//   out_vdata  out  WIDTH  line y, 0..V_TOTAL-1
//   out_de     out  1      high inside the visible area
//   out_frame  out  1      high while outputs show (0,0)
// ---------------------------------------------------------------------------
module vga_timing #(
  parameter int   WIDTH    = 11,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic H_POL    = 1'b0,
  parameter logic V_POL    = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  output logic             out_hsync,
  output logic             out_vsync,
  output logic [WIDTH-1:0] out_hdata,
  output logic [WIDTH-1:0] out_vdata,
  output logic             out_de,
  output logic             out_frame
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [WIDTH-1:0] H_LAST = WIDTH'(H_TOTAL - 1);
  localparam logic [WIDTH-1:0] V_LAST = WIDTH'(V_TOTAL - 1);
  localparam logic [WIDTH-1:0] ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

  // Region boundaries carry one extra bit so that a boundary equal to the
  // total (zero back porch) still compares correctly.
  localparam logic [WIDTH:0] H_ACT_B = (WIDTH+1)'(H_ACTIVE);
  localparam logic [WIDTH:0] H_SS_B  = (WIDTH+1)'(H_ACTIVE + H_FP);
  localparam logic [WIDTH:0] H_SE_B  = (WIDTH+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [WIDTH:0] V_ACT_B = (WIDTH+1)'(V_ACTIVE);
  localparam logic [WIDTH:0] V_SS_B  = (WIDTH+1)'(V_ACTIVE + V_FP);
  localparam logic [WIDTH:0] V_SE_B  = (WIDTH+1)'(V_ACTIVE + V_FP + V_SYNC);

  logic [WIDTH-1:0] r_hc;
  logic [WIDTH-1:0] r_vc;

  logic [WIDTH-1:0] w_hc_next;
  logic [WIDTH-1:0] w_vc_next;
  logic [WIDTH:0]   w_hc_x;
  logic [WIDTH:0]   w_vc_x;
  logic             w_de;
  logic             w_hsync;
  logic             w_vsync;
  logic             w_frame;

  // Next counter values: hc wraps at end of line, vc steps only on that wrap.
  always_comb begin
    w_hc_next = r_hc;
    w_vc_next = r_vc;
    if (r_hc == H_LAST) begin
      w_hc_next = '0;
      if (r_vc == V_LAST) begin
        w_vc_next = '0;
      end else begin
        w_vc_next = r_vc + ONE;
      end
    end else begin
      w_hc_next = r_hc + ONE;
      w_vc_next = r_vc;
    end
  end

  // Decode the current counter position into the video control signals.
  always_comb begin
    w_hc_x  = {1'b0, r_hc};
    w_vc_x  = {1'b0, r_vc};
    w_de    = (w_hc_x < H_ACT_B) && (w_vc_x < V_ACT_B);
    // vsync depends only on vc, so it naturally changes with hdata=0.
    w_hsync = ((w_hc_x >= H_SS_B) && (w_hc_x < H_SE_B)) ? H_POL : ~H_POL;
    w_vsync = ((w_vc_x >= V_SS_B) && (w_vc_x < V_SE_B)) ? V_POL : ~V_POL;
    w_frame = (r_hc == '0) && (r_vc == '0);
  end

  // Counter and output registers; rst wins over ce, ce=0 holds everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hc      <= '0;
      r_vc      <= '0;
      out_hdata <= '0;
      out_vdata <= '0;
      out_de    <= 1'b0;
      out_frame <= 1'b0;
      out_hsync <= ~H_POL;
      out_vsync <= ~V_POL;
    end else if (ce) begin
      r_hc      <= w_hc_next;
      r_vc      <= w_vc_next;
      out_hdata <= r_hc;
      out_vdata <= r_vc;
      out_de    <= w_de;
      out_frame <= w_frame;
      out_hsync <= w_hsync;
      out_vsync <= w_vsync;
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// ---------------------------------------------------------------------------
// tb_vga_timing
//   Directed bench for vga_timing with a small raster (H_TOTAL=8, V_TOTAL=6).
//   Two instances share clk/rst/ce: u_neg uses active-low syncs, u_pos
//   active-high syncs. Expected values come from hand-derived region rules
//   for this raster: visible when h<4 && v<3, hsync active at h=5,6,
//   vsync active at v=4, frame at (0,0).
// ---------------------------------------------------------------------------
module tb_vga_timing;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce;

  logic       hs0, vs0, de0, fr0;
  logic [3:0] hd0, vd0;
  logic       hs1, vs1, de1, fr1;
  logic [3:0] hd1, vd1;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: (mh,mv) is the counter value the next ce cycle will show,
  // (ph,pv) is what the outputs currently show.
  int mh, mv, ph, pv;
  int cyc;
  int last_frame;

  always #5 clk = ~clk;

  vga_timing #(
    .WIDTH(4), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0)
  ) u_neg (
    .clk(clk), .rst(rst), .ce(ce),
    .out_hsync(hs0), .out_vsync(vs0), .out_hdata(hd0), .out_vdata(vd0),
    .out_de(de0), .out_frame(fr0)
  );

  vga_timing #(
    .WIDTH(4), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1)
  ) u_pos (
    .clk(clk), .rst(rst), .ce(ce),
    .out_hsync(hs1), .out_vsync(vs1), .out_hdata(hd1), .out_vdata(vd1),
    .out_de(de1), .out_frame(fr1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_pos(input string tag, input int h, input int v);
    chk({tag, ".hdata"}, 32'(hd0), h);
    chk({tag, ".vdata"}, 32'(vd0), v);
    chk({tag, ".de"},    32'(de0), ((h < 4) && (v < 3)) ? 1 : 0);
    chk({tag, ".hsync"}, 32'(hs0), ((h == 5) || (h == 6)) ? 0 : 1);
    chk({tag, ".vsync"}, 32'(vs0), (v == 4) ? 0 : 1);
    chk({tag, ".frame"}, 32'(fr0), ((h == 0) && (v == 0)) ? 1 : 0);
    chk({tag, ".hsync_p"}, 32'(hs1), ((h == 5) || (h == 6)) ? 1 : 0);
    chk({tag, ".vsync_p"}, 32'(vs1), (v == 4) ? 1 : 0);
    chk({tag, ".xy_p"},  32'({hd1, vd1, de1, fr1}), 32'({hd0, vd0, de0, fr0}));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".hdata"}, 32'(hd0), 0);
    chk({tag, ".vdata"}, 32'(vd0), 0);
    chk({tag, ".de"},    32'(de0), 0);
    chk({tag, ".frame"}, 32'(fr0), 0);
    chk({tag, ".hsync"}, 32'(hs0), 1);
    chk({tag, ".vsync"}, 32'(vs0), 1);
    chk({tag, ".hsync_p"}, 32'(hs1), 0);
    chk({tag, ".vsync_p"}, 32'(vs1), 0);
  endtask

  // One ce=1 pixel: outputs must show the model position, then model advances.
  task automatic adv(input string tag);
    ce = 1'b1;
    step();
    cyc++;
    ph = mh;
    pv = mv;
    check_pos(tag, ph, pv);
    if (fr0 === 1'b1) begin
      if (last_frame >= 0) chk({tag, ".frame_period"}, cyc - last_frame, 48);
      last_frame = cyc;
    end
    if (mh == 7) begin
      mh = 0;
      mv = (mv == 5) ? 0 : mv + 1;
    end else begin
      mh = mh + 1;
    end
  endtask

  task automatic walk_to(input string tag, input int h, input int v);
    for (int i = 0; i < 120; i++) begin
      if ((ph == h) && (pv == v)) break;
      adv(tag);
    end
    chk({tag, ".reached"}, 32'({hd0, vd0}), 32'({4'(h), 4'(v)}));
  endtask

  initial begin
    mh = 0; mv = 0; ph = -1; pv = -1;
    cyc = 0; last_frame = -1;

    // Reset held for two clocks.
    rst = 1'b1;
    ce  = 1'b1;
    step();
    step();
    check_reset("reset");

    // First cycle after reset shows (0,0) with de and frame.
    rst = 1'b0;
    adv("first");

    // Two full frames plus a little: line scan, vsync, frame period.
    for (int i = 0; i < 100; i++) adv("scan");

    // Pixel enable dropped while hdata=2.
    walk_to("to_h2", 2, 1);
    ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_pos("ce_hold", ph, pv);
    end
    adv("ce_resume");
    chk("ce_resume.no_skip", 32'(hd0), 3);

    // Frame pulse holds through ce=0.
    walk_to("to_origin", 0, 0);
    ce = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check_pos("frame_hold", 0, 0);
    end
    last_frame = -1;
    adv("frame_resume");

    // Mid-frame reset during vsync.
    walk_to("to_h6v4", 6, 4);
    chk("pre_rst.vsync", 32'(vs0), 0);
    rst = 1'b1;
    step();
    check_reset("mid_reset");
    rst = 1'b0;
    mh = 0; mv = 0;
    last_frame = -1;
    adv("restart");
    chk("restart.frame", 32'(fr0), 1);
    chk("restart.vsync", 32'(vs0), 1);
    for (int i = 0; i < 10; i++) adv("post_restart");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
